// File: rtl/synth_pkg.sv
// ---------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the SPI register-write front end of the synth.
//   SPI_FRAME_BITS    : serial frame length (32, or 33 with parity)
//   SPI_DATA_BITS     : payload bits carried by a frame
//   REG_NUM_* / REG_VAL_* : field positions inside the 32-bit payload
//   SpiWriterState_t  : frame FSM states
// Optional feature macro: SPI_REGISTER_WRITER_PARITY_EN (adds a trailing
// even-parity bit to every frame).
// ---------------------------------------------------------------------------
package synth_pkg;

`ifdef SPI_REGISTER_WRITER_PARITY_EN
  localparam int SPI_FRAME_BITS = 33;
`else
  localparam int SPI_FRAME_BITS = 32;
`endif

  localparam int SPI_DATA_BITS = 32;

  localparam int REG_NUM_MSB = 31;
  localparam int REG_NUM_LSB = 16;
  localparam int REG_VAL_MSB = 15;
  localparam int REG_VAL_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } SpiWriterState_t;

endpackage

// File: rtl/spi_input_sync.sv
// ---------------------------------------------------------------------------
// spi_input_sync
// Multi-flop synchronizer bringing one asynchronous SPI pin into the i_Clock
// domain. The chain resets to RESET_VALUE so the bus looks idle after reset.
//   i_Clock   : system clock
//   i_Reset   : synchronous, active-high reset
//   async_in  : asynchronous input pin
//   sync_out  : synchronized level (SYNC_STAGES cycles of latency)
// ---------------------------------------------------------------------------
module spi_input_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] stages;

  // NOTE: non-blocking assignment, so each stage takes the previous stage's
  // old value and the chain really is SYNC_STAGES flops deep.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      stages <= {SYNC_STAGES{RESET_VALUE}};
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = stages[SYNC_STAGES-1];

endmodule

// File: rtl/spi_register_writer.sv
// ---------------------------------------------------------------------------
// spi_register_writer
// SPI (mode 0) slave that turns each 32-bit frame {register[15:0],
// value[15:0]} into a single-cycle register write strobe. Malformed frames
// (wrong bit count, or bad parity) give a single-cycle o_FrameError instead.
// MISO echoes the previously accepted frame, MSB first.
//   i_Clock / i_Reset     : system clock, synchronous active-high reset
//   i_SpiClock            : SCLK, asynchronous, must be <= i_Clock/4
//   i_SpiChipSelect_n     : frame enable, active-low, asynchronous
//   i_SpiMosi             : serial data in, MSB first
//   o_SpiMiso             : echo of last accepted frame (0 while CS_n high)
//   o_RegisterNumber      : register address of the last committed write
//   o_RegisterValue       : register data of the last committed write
//   o_RegisterWriteEnable : one-cycle write strobe
//   o_FrameError          : one-cycle pulse, frame discarded
// Optional feature macro: SPI_REGISTER_WRITER_PARITY_EN (33-bit frames whose
// bit 0 makes the whole frame even parity).
// ---------------------------------------------------------------------------
module spi_register_writer
  import synth_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_SpiClock,
  input  logic        i_SpiChipSelect_n,
  input  logic        i_SpiMosi,
  output logic        o_SpiMiso,
  output logic [15:0] o_RegisterNumber,
  output logic [15:0] o_RegisterValue,
  output logic        o_RegisterWriteEnable,
  output logic        o_FrameError
);

  // Synchronized pins and their one-cycle-delayed copies.
  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_d, cs_n_d;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_sclk (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .async_in(i_SpiClock), .sync_out(sclk_s));
  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_cs_n (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .async_in(i_SpiChipSelect_n), .sync_out(cs_n_s));
  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .async_in(i_SpiMosi), .sync_out(mosi_s));

  logic sclk_rise, sclk_fall, cs_rise;
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_n_s & ~cs_n_d;

  // A frame may start only after CS_n has been seen high with a flushed
  // synchronizer. This keeps a CS_n still low across reset from looking like
  // a new frame, and lets a CS_n fall during COMMIT start the next frame
  // from IDLE one cycle later (the start test is on the level, not a pulse).
  logic [2:0] flush_cnt;
  logic       flushed;
  logic       armed;
  assign flushed = (flush_cnt == 3'(SYNC_STAGES));

  SpiWriterState_t state, state_next;
  logic            start_frame, end_frame;

  logic [5:0]                bit_cnt;
  logic [SPI_FRAME_BITS-1:0] shift_reg;
  logic [SPI_DATA_BITS-1:0]  echo_reg;
  logic [SPI_DATA_BITS-1:0]  miso_shift;
  logic [SPI_DATA_BITS-1:0]  frame_data;
  logic                      frame_ok;

`ifdef SPI_REGISTER_WRITER_PARITY_EN
  assign frame_data = shift_reg[SPI_FRAME_BITS-1:1];
  assign frame_ok   = (bit_cnt == 6'(SPI_FRAME_BITS)) && !(^shift_reg);
`else
  assign frame_data = shift_reg;
  assign frame_ok   = (bit_cnt == 6'(SPI_FRAME_BITS));
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (armed && !cs_n_s) begin
          start_frame = 1'b1;
          state_next  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          end_frame  = 1'b1;
          state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sclk_d                <= 1'b0;
      cs_n_d                <= 1'b1;
      flush_cnt             <= '0;
      armed                 <= 1'b0;
      bit_cnt               <= '0;
      shift_reg             <= '0;
      echo_reg              <= '0;
      miso_shift            <= '0;
      o_RegisterNumber      <= '0;
      o_RegisterValue       <= '0;
      o_RegisterWriteEnable <= 1'b0;
      o_FrameError          <= 1'b0;
    end else begin
      sclk_d                <= sclk_s;
      cs_n_d                <= cs_n_s;
      o_RegisterWriteEnable <= 1'b0;
      o_FrameError          <= 1'b0;

      if (!flushed) flush_cnt <= flush_cnt + 3'd1;

      if (start_frame)            armed <= 1'b0;
      else if (flushed && cs_n_s) armed <= 1'b1;

      if (start_frame) begin
        bit_cnt    <= '0;
        shift_reg  <= '0;
        miso_shift <= echo_reg;
      end else if (state == ST_SHIFT) begin
        if (sclk_rise) begin
          shift_reg <= {shift_reg[SPI_FRAME_BITS-2:0], mosi_s};
          if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
        end
        if (sclk_fall) miso_shift <= {miso_shift[SPI_DATA_BITS-2:0], 1'b0};
      end

      // Registered here so the strobe and data appear in the COMMIT cycle.
      if (end_frame) begin
        if (frame_ok) begin
          o_RegisterWriteEnable <= 1'b1;
          o_RegisterNumber      <= frame_data[REG_NUM_MSB:REG_NUM_LSB];
          o_RegisterValue       <= frame_data[REG_VAL_MSB:REG_VAL_LSB];
          echo_reg              <= frame_data;
        end else begin
          o_FrameError <= 1'b1;
        end
      end
    end
  end

  assign o_SpiMiso = (state == ST_SHIFT) && !cs_n_s && miso_shift[SPI_DATA_BITS-1];

endmodule

// File: tb/tb_spi_register_writer.sv
// ---------------------------------------------------------------------------
// tb_spi_register_writer
// Directed bench for spi_register_writer: SCLK = i_Clock/8, inputs driven
// on the falling edge of i_Clock, outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_spi_register_writer;

`ifdef SPI_REGISTER_WRITER_PARITY_EN
  localparam int FRAME_N = 33;
`else
  localparam int FRAME_N = 32;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] reg_num;
  logic [15:0] reg_val;
  logic        reg_we;
  logic        frame_err;

  int vectors     = 0;
  int miscompares = 0;
  int we_pulses   = 0;
  int err_pulses  = 0;
  int both_high   = 0;

  always #5 clk = ~clk;

  spi_register_writer #(.SYNC_STAGES(2)) dut (
    .i_Clock              (clk),
    .i_Reset              (rst),
    .i_SpiClock           (sclk),
    .i_SpiChipSelect_n    (cs_n),
    .i_SpiMosi            (mosi),
    .o_SpiMiso            (miso),
    .o_RegisterNumber     (reg_num),
    .o_RegisterValue      (reg_val),
    .o_RegisterWriteEnable(reg_we),
    .o_FrameError         (frame_err)
  );

  always @(negedge clk) begin
    if (reg_we)              we_pulses++;
    if (frame_err)           err_pulses++;
    if (reg_we && frame_err) both_high++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Frame bits for a 32-bit payload, with the even-parity bit appended
  // when parity is enabled.
  function automatic logic [39:0] frame_of(input logic [31:0] d);
`ifdef SPI_REGISTER_WRITER_PARITY_EN
    return {7'b0, d, ^d};
`else
    return {8'b0, d};
`endif
  endfunction

  // Lowers CS_n, clocks nbits bits MSB first and captures MISO just before
  // each SCLK rise. reset_after >= 0 pulses i_Reset after that many bits.
  // CS_n is left low; close_frame raises it.
  task automatic send_bits(input logic [39:0] data, input int nbits, input int reset_after,
                           output logic [39:0] miso_bits);
    miso_bits = '0;
    @(negedge clk);
    cs_n = 1'b0;
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = data[i];
      repeat (4) @(negedge clk);
      miso_bits = {miso_bits[38:0], miso};
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      if (nbits - i == reset_after) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    mosi = 1'b0;
  endtask

  // Raises CS_n and records in which sampled cycle (1-based) the strobe and
  // the error pulse first appear; 0 means never within the window.
  task automatic close_frame(output int we_at, output int err_at);
    we_at  = 0;
    err_at = 0;
    cs_n   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (reg_we && we_at == 0)     we_at = k;
      if (frame_err && err_at == 0) err_at = k;
    end
  endtask

  initial begin
    logic [39:0] mb;
    int          we_at, err_at;
    int          exp_we, exp_err;

    exp_we  = 0;
    exp_err = 0;

    // Reset state.
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_we",   32'(reg_we),    32'h0);
    check("rst_err",  32'(frame_err), 32'h0);
    check("rst_num",  32'(reg_num),   32'h0);
    check("rst_val",  32'(reg_val),   32'h0);
    check("rst_miso", 32'(miso),      32'h0);

    // Single good frame: strobe three samples after CS_n rises
    // (two synchronizer flops, then the registered commit).
    send_bits(frame_of(32'h1002_ABCD), FRAME_N, -1, mb);
    close_frame(we_at, err_at);
    exp_we++;
    check("a_we_lat",  32'(we_at),  32'd3);
    check("a_err",     32'(err_at), 32'd0);
    check("a_num",     32'(reg_num), 32'h1002);
    check("a_val",     32'(reg_val), 32'hABCD);
    check("a_miso",    32'(mb >> (FRAME_N - 32)), 32'h0);
    check("a_miso_hi", 32'(miso), 32'h0);

    // Short (31-bit) and long (40-bit) frames are rejected.
    send_bits(40'h00_7FFF_FFFF, 31, -1, mb);
    close_frame(we_at, err_at);
    exp_err++;
    check("short_err", 32'(err_at), 32'd3);
    check("short_we",  32'(we_at),  32'd0);
    send_bits(40'hAA_5555_5555, 40, -1, mb);
    close_frame(we_at, err_at);
    exp_err++;
    check("long_err", 32'(err_at),  32'd3);
    check("long_we",  32'(we_at),   32'd0);
    check("long_num", 32'(reg_num), 32'h1002);
    check("long_val", 32'(reg_val), 32'hABCD);

    // Back-to-back frames; each echoes the previously accepted frame.
    send_bits(frame_of(32'h0801_0001), FRAME_N, -1, mb);
    close_frame(we_at, err_at);
    exp_we++;
    check("b_miso", 32'(mb >> (FRAME_N - 32)), 32'h1002_ABCD);
    check("b_we",   32'(we_at),   32'd3);
    check("b_num",  32'(reg_num), 32'h0801);
    check("b_val",  32'(reg_val), 32'h0001);
    send_bits(frame_of(32'h0803_7FFF), FRAME_N, -1, mb);
    close_frame(we_at, err_at);
    exp_we++;
    check("c_miso", 32'(mb >> (FRAME_N - 32)), 32'h0801_0001);
    check("c_we",   32'(we_at),   32'd3);
    check("c_num",  32'(reg_num), 32'h0803);
    check("c_val",  32'(reg_val), 32'h7FFF);

    // Reset after bit 12 with CS_n held low: frame silently dropped.
    send_bits(frame_of(32'hDEAD_BEEF), FRAME_N, 12, mb);
    close_frame(we_at, err_at);
    check("rmid_we",  32'(we_at),   32'd0);
    check("rmid_err", 32'(err_at),  32'd0);
    check("rmid_num", 32'(reg_num), 32'h0);
    check("rmid_val", 32'(reg_val), 32'h0);

    // Next full frame commits; the echo was cleared by reset.
    send_bits(frame_of(32'h1234_5678), FRAME_N, -1, mb);
    close_frame(we_at, err_at);
    exp_we++;
    check("d_miso", 32'(mb >> (FRAME_N - 32)), 32'h0);
    check("d_we",   32'(we_at),   32'd3);
    check("d_num",  32'(reg_num), 32'h1234);
    check("d_val",  32'(reg_val), 32'h5678);

    // SCLK activity with CS_n high is ignored; then a zero-clock frame.
    for (int i = 0; i < 5; i++) begin
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    check("idle_sclk_err", 32'(err_pulses), 32'(exp_err));
    check("idle_sclk_we",  32'(we_pulses),  32'(exp_we));
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    close_frame(we_at, err_at);
    exp_err++;
    check("zero_err", 32'(err_at), 32'd3);
    check("zero_we",  32'(we_at),  32'd0);

`ifdef SPI_REGISTER_WRITER_PARITY_EN
    // Flipped parity bit is rejected; correct parity is accepted.
    send_bits(frame_of(32'h1002_ABCD) ^ 40'd1, FRAME_N, -1, mb);
    close_frame(we_at, err_at);
    exp_err++;
    check("par_bad_err", 32'(err_at),  32'd3);
    check("par_bad_we",  32'(we_at),   32'd0);
    check("par_bad_num", 32'(reg_num), 32'h1234);
    send_bits(frame_of(32'h1002_ABCD), FRAME_N, -1, mb);
    close_frame(we_at, err_at);
    exp_we++;
    check("par_ok_we",  32'(we_at),   32'd3);
    check("par_ok_num", 32'(reg_num), 32'h1002);
    check("par_ok_val", 32'(reg_val), 32'hABCD);
`endif

    // Whole-run pulse accounting.
    check("tot_we",   32'(we_pulses),  32'(exp_we));
    check("tot_err",  32'(err_pulses), 32'(exp_err));
    check("tot_both", 32'(both_high),  32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
